// File: rtl/stone_tile_pkg.sv
// stone_tile_pkg: shared tile geometry, FSM state and clear-queue entry types
package stone_tile_pkg;
  localparam int TILE_BITS = 5;
  localparam int TILE_SIZE = 32;
  typedef enum logic [1:0] {INIT, IDLE, APPLY} state_t;
  typedef struct packed {
    logic [5:0] row;
    logic [5:0] col;
  } clear_entry_t;
endpackage

// File: rtl/stone_tile_controller_fifo.sv
// tile_clear_fifo: synchronous FIFO of pending tile-clear entries with flush
module tile_clear_fifo
  import stone_tile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  clear_entry_t din,
  output clear_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic         one
);
  localparam int AW = $clog2(DEPTH);
  clear_entry_t mem [DEPTH];
  logic [AW:0] wp, rp, cnt;
  assign cnt   = wp - rp;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign one   = cnt == (AW+1)'(1);
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/stone_tile_controller.sv
// stone_tile_controller: tile occupancy map, bitmap addressing and frame-synchronous tile clears.
// Optional horizontal scroll via TILE_SCROLL_EN.
module stone_tile_controller
  import stone_tile_pkg::*;
#(
  parameter int TOP_LEFT_X  = 64,
  parameter int TOP_LEFT_Y  = 32,
  parameter int GRID_COLS   = 16,
  parameter int GRID_ROWS   = 8,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [GRID_COLS*GRID_ROWS-1:0] INITIAL_PATTERN = '1,
  parameter int CNT_W = $clog2(GRID_COLS*GRID_ROWS+1)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef TILE_SCROLL_EN
  input  logic [10:0]      scrollX,
`endif
  input  logic [10:0]      pixelX,
  input  logic [10:0]      pixelY,
  input  logic             startOfFrame,
  input  logic             levelLoad,
  input  logic             clearReq,
  input  logic [10:0]      clearX,
  input  logic [10:0]      clearY,
  output logic             clearAck,
  output logic             insideRectangle,
  output logic [10:0]      offsetX,
  output logic [10:0]      offsetY,
  output logic             busy,
  output logic [CNT_W-1:0] tilesRemaining,
  output logic             levelCleared
);
  localparam int N  = GRID_COLS*GRID_ROWS;
  localparam int IW = $clog2(N);
  localparam logic [11:0] GW = 12'(GRID_COLS*TILE_SIZE);
  localparam logic [11:0] X0 = 12'(TOP_LEFT_X);
  localparam logic [11:0] X1 = 12'(TOP_LEFT_X + GRID_COLS*TILE_SIZE);
  localparam logic [11:0] Y0 = 12'(TOP_LEFT_Y);
  localparam logic [11:0] Y1 = 12'(TOP_LEFT_Y + GRID_ROWS*TILE_SIZE);
  state_t state, next_state;
  logic [N-1:0] map;
  logic [IW-1:0] idx, pidx, hidx;
  logic [CNT_W-1:0] next_cnt;
  logic [10:0] prx, pry, crx, cry;
  logic pin, cin, draw, accept, push, pop, hit, full, empty, one;
  clear_entry_t centry, head;
`ifdef TILE_SCROLL_EN
  logic [10:0] scroll_q;
  always_ff @(posedge clk)
    if (reset) scroll_q <= '0;
    else if (startOfFrame) scroll_q <= scrollX;
`endif
  function automatic logic [10:0] wrap_x(input logic [10:0] rx);
`ifdef TILE_SCROLL_EN
    return 11'((12'(rx) + 12'(scroll_q)) % GW);
`else
    return rx;
`endif
  endfunction
  function automatic logic in_grid(input logic [10:0] x, input logic [10:0] y);
    return {1'b0, x} >= X0 && {1'b0, x} < X1 && {1'b0, y} >= Y0 && {1'b0, y} < Y1;
  endfunction
  function automatic logic [IW-1:0] tile_idx(input logic [5:0] row, input logic [5:0] col);
    return IW'(int'(row)*GRID_COLS + int'(col));
  endfunction
  // The grid test uses unscrolled coordinates; only the column lookup is wrapped
  assign prx    = wrap_x(pixelX - 11'(TOP_LEFT_X));
  assign pry    = pixelY - 11'(TOP_LEFT_Y);
  assign pin    = in_grid(pixelX, pixelY);
  assign pidx   = tile_idx(pry[10:TILE_BITS], prx[10:TILE_BITS]);
  assign draw   = pin && map[pidx] && state != INIT;
  assign crx    = wrap_x(clearX - 11'(TOP_LEFT_X));
  assign cry    = clearY - 11'(TOP_LEFT_Y);
  assign cin    = in_grid(clearX, clearY);
  assign centry = '{row: cry[10:TILE_BITS], col: crx[10:TILE_BITS]};
  // Gating on clearAck keeps a still-high request from being queued twice
  assign accept = clearReq && !clearAck && !full && state != INIT && !levelLoad;
  assign push   = accept && cin;
  assign pop    = state == APPLY && !empty && !levelLoad;
  assign hidx   = tile_idx(head.row, head.col);
  assign hit    = pop && map[hidx];
  tile_clear_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .push(push), .pop(pop), .flush(levelLoad),
    .din(centry), .dout(head), .full(full), .empty(empty), .one(one)
  );
  always_comb begin
    next_state = state;
    next_cnt   = tilesRemaining;
    if (levelLoad) begin
      next_state = INIT;
      next_cnt   = '0;
    end else if (state == INIT) begin
      next_cnt   = tilesRemaining + CNT_W'(INITIAL_PATTERN[idx]);
      next_state = idx == IW'(N-1) ? IDLE : INIT;
    end else if (state == IDLE) begin
      next_state = startOfFrame && !empty ? APPLY : IDLE;
    end else begin
      next_cnt   = hit ? tilesRemaining - CNT_W'(1) : tilesRemaining;
      next_state = !push && (empty || one) ? IDLE : APPLY;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= INIT;
      idx             <= '0;
      tilesRemaining  <= '0;
      busy            <= 1'b1;
      levelCleared    <= 1'b0;
      clearAck        <= 1'b0;
      insideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      state           <= next_state;
      idx             <= levelLoad || state != INIT ? '0 : idx + 1'b1;
      tilesRemaining  <= next_cnt;
      busy            <= next_state != IDLE;
      levelCleared    <= next_state == IDLE && next_cnt == '0;
      clearAck        <= accept;
      insideRectangle <= draw;
      offsetX         <= draw ? {6'd0, prx[4:0]} : '0;
      offsetY         <= draw ? {6'd0, pry[4:0]} : '0;
    end
  end
  always_ff @(posedge clk)
    if (!levelLoad && state == INIT) map[idx] <= INITIAL_PATTERN[idx];
    else if (hit) map[hidx] <= 1'b0;
endmodule

// File: doc/stone_tile_controller.md
Name: stone_tile_controller

Overview:
- Sequences the 32x32 stone background bitmap across a rectangular grid of tiles.
- Keeps a one-bit-per-tile occupancy map and, for each scanned pixel, drives the bitmap's insideRectangle and offsetX/offsetY inputs.
- Queues collision-driven tile-clear requests and applies them only at frame start, so a tile never disappears mid-frame.
- Sits between the VGA pixel counter / collision logic and the stone bitmap block.

Parameters:
- TOP_LEFT_X, 64, pixel X of the grid's left edge
- TOP_LEFT_Y, 32, pixel Y of the grid's top edge
- GRID_COLS, 16, tiles per row
- GRID_ROWS, 8, tile rows; N = GRID_COLS*GRID_ROWS
- QUEUE_DEPTH, 4, clear-request FIFO entries (power of two)
- INITIAL_PATTERN, all ones (N bits), map content loaded on INIT; bit index = row*GRID_COLS+col
- CNT_W, $clog2(N+1), width of tilesRemaining

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- startOfFrame  in  1  one-cycle pulse at frame start
- levelLoad  in  1  one-cycle pulse; reload map from INITIAL_PATTERN
- clearReq  in  1  request to clear the tile under (clearX, clearY); held until ack
- clearX  in  11  collision pixel X
- clearY  in  11  collision pixel Y
- clearAck  out  1  one-cycle acceptance pulse
- insideRectangle  out  1  to bitmap: draw tile at this pixel
- offsetX  out  11  to bitmap: X offset within tile (0..31)
- offsetY  out  11  to bitmap: Y offset within tile (0..31)
- busy  out  1  FSM not in IDLE
- tilesRemaining  out  CNT_W  count of set map bits
- levelCleared  out  1  tilesRemaining==0 and FSM in IDLE

Behaviour:
- Reset values:
  - insideRectangle, offsetX, offsetY, clearAck, tilesRemaining, levelCleared all 0.
  - FIFO emptied; FSM goes to INIT; busy=1.
- Pixel path, registered, latency 1 cycle:
  - relX = pixelX - TOP_LEFT_X; relY = pixelY - TOP_LEFT_Y.
  - inGrid when 0 <= relX < GRID_COLS*32 and 0 <= relY < GRID_ROWS*32.
  - col = relX>>5; row = relY>>5.
  - insideRectangle = inGrid && map[row*GRID_COLS+col] && state!=INIT.
  - offsetX = relX[4:0] and offsetY = relY[4:0], zero-extended, when insideRectangle; otherwise both 0.
- FSM states INIT, IDLE, APPLY:
  - INIT: index counter 0..N-1, one map bit per cycle from INITIAL_PATTERN; tilesRemaining recomputed incrementally from 0. After N cycles go to IDLE.
  - IDLE: on startOfFrame with FIFO non-empty, go to APPLY.
  - APPLY: pop one entry per cycle. If the bit is set, clear it and decrement tilesRemaining; a duplicate clear of an already-cleared tile has no effect. When the FIFO is empty at the end of a pop cycle, go to IDLE.
  - levelLoad in any state: flush FIFO, reset index, go to INIT. levelLoad has priority over startOfFrame.
- Clear handshake:
  - clearReq is sampled each cycle. When the FIFO is not full and state!=INIT, push {row,col} and pulse clearAck on the next cycle.
  - After clearAck the requester drops clearReq. The controller never acks the same request twice: no push on the cycle clearAck is high.
  - Coordinates outside the grid are acked and dropped (no push).
  - FIFO full or INIT: no ack; the request is held.
  - Push and pop in the same cycle in APPLY are both performed; an entry pushed during APPLY is applied in the same burst.
- levelCleared and busy are registered from next-state values.
- levelCleared is never 1 during INIT.

Optional Feature:
- TILE_SCROLL_EN defined:
  - Adds input scrollX[10:0], latched at startOfFrame.
  - Effective relX = (pixelX - TOP_LEFT_X + scrollX_latched) mod (GRID_COLS*32) for in-grid pixels; the inGrid test uses the unscrolled relX.
  - Clear coordinates are translated the same way.
- Undefined: no port, scroll is 0.

Decomposition:
- Package stone_tile_pkg holds:
  - TILE_BITS=5, TILE_SIZE=32
  - state enum {INIT, IDLE, APPLY}
  - clear_entry_t struct {row, col}
- One sub-module, tile_clear_fifo: synchronous FIFO of clear_entry_t with push/pop/full/empty/flush.

Test Plan (defaults, all-ones pattern):
- Reset, wait 128 cycles -> busy=0, tilesRemaining=128. Pixel (100,50) -> next cycle insideRectangle=1, offsetX=4, offsetY=18.
- Pixels (63,50), (576,50), (100,288) -> insideRectangle=0, offsets 0.
- clearReq at (100,50) mid-frame -> clearAck next cycle; (100,50) still drawn. After startOfFrame plus 2 cycles -> insideRectangle=0 at (100,50), tilesRemaining=127.
- Five distinct requests, no startOfFrame -> 4 acks, 5th held. After startOfFrame -> 5th acked, tilesRemaining drops by 5 in total.
- Two clears of the same tile -> tilesRemaining decrements by 1.
- levelLoad during APPLY -> FIFO flushed, busy=1 for 128 cycles, tilesRemaining=128. Clearing all 128 tiles -> levelCleared=1.
